// File: rtl/conway_mode_controller.sv
// Command sequencer for the cell-state memory: steps LOAD, RUN and READ and drives
// the memory's mutually exclusive mode controls for exact cycle counts.
module conway_mode_controller #(
  parameter int DATA_SIZE = 5,
  parameter int GEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [GEN_WIDTH-1:0] cmd_gens,
  output logic                 cmd_ready,
  input  logic                 cmd_abort,
  input  logic                 host_bit_valid,
  input  logic                 host_bit,
  output logic                 load_mode,
  output logic                 run_mode,
  output logic                 output_mode,
  output logic                 serial_in,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = $clog2(DATA_SIZE + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);
  localparam logic [GEN_WIDTH-1:0] GEN_ONE = GEN_WIDTH'(1);

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_READ = 2'b11
  } state_t;

  state_t               state_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [GEN_WIDTH-1:0] gen_cnt_r;
  logic                 run_mode_r;
  logic                 output_mode_r;
  logic                 busy_r;
  logic                 cmd_ready_r;
  logic                 done_r;
  logic                 out_valid_r;

  logic                 accept_s;
  logic                 abort_s;
  logic                 finish_s;

  // Abort outranks a same-cycle command; finishing is the last counted mode cycle.
  always_comb begin
    accept_s = cmd_valid & cmd_ready_r & ~cmd_abort;
    abort_s  = cmd_abort & (state_r != ST_IDLE);
    finish_s = 1'b0;
    case (state_r)
      ST_LOAD: finish_s = host_bit_valid & (bit_cnt_r == LAST_BIT);
      ST_RUN:  finish_s = (gen_cnt_r == GEN_ONE);
      ST_READ: finish_s = (bit_cnt_r == LAST_BIT);
      default: finish_s = 1'b0;
    endcase
  end

  // Sequencer FSM; mode, busy and ready flags are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= {BIT_W{1'b0}};
      gen_cnt_r     <= {GEN_WIDTH{1'b0}};
      run_mode_r    <= 1'b0;
      output_mode_r <= 1'b0;
      busy_r        <= 1'b0;
      cmd_ready_r   <= 1'b1;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort_s || finish_s) begin
        state_r       <= ST_IDLE;
        bit_cnt_r     <= {BIT_W{1'b0}};
        gen_cnt_r     <= {GEN_WIDTH{1'b0}};
        run_mode_r    <= 1'b0;
        output_mode_r <= 1'b0;
        busy_r        <= 1'b0;
        cmd_ready_r   <= 1'b1;
        done_r        <= ~abort_s;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s) begin
              case (cmd_op)
                OP_LOAD: begin
                  state_r     <= ST_LOAD;
                  bit_cnt_r   <= {BIT_W{1'b0}};
                  busy_r      <= 1'b1;
                  cmd_ready_r <= 1'b0;
                end
                OP_RUN: begin
                  if (cmd_gens == {GEN_WIDTH{1'b0}}) begin
                    done_r <= 1'b1;
                  end else begin
                    state_r     <= ST_RUN;
                    gen_cnt_r   <= cmd_gens;
                    run_mode_r  <= 1'b1;
                    busy_r      <= 1'b1;
                    cmd_ready_r <= 1'b0;
                  end
                end
                OP_READ: begin
                  state_r       <= ST_READ;
                  bit_cnt_r     <= {BIT_W{1'b0}};
                  output_mode_r <= 1'b1;
                  busy_r        <= 1'b1;
                  cmd_ready_r   <= 1'b0;
                end
                default: begin
                  state_r <= ST_IDLE;
                end
              endcase
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_LOAD: begin
            if (host_bit_valid) begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end else begin
              bit_cnt_r <= bit_cnt_r;
            end
          end
          ST_RUN: begin
            gen_cnt_r <= gen_cnt_r - GEN_ONE;
          end
          ST_READ: begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // serial_out is valid the cycle after each shift, so this survives an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= output_mode_r;
    end
  end

  // load_mode follows host_bit_valid directly so each valid bit shifts exactly once.
  assign load_mode   = (state_r == ST_LOAD) & host_bit_valid;
  assign run_mode    = run_mode_r;
  assign output_mode = output_mode_r;
  assign serial_in   = host_bit;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign cmd_ready   = cmd_ready_r;
  assign done        = done_r;

  conway_mode_checker u_checker (
    .clk         (clk),
    .reset       (reset),
    .load_mode   (load_mode),
    .run_mode    (run_mode),
    .output_mode (output_mode)
  );

endmodule

// Property checker: the memory must never see two mode controls at once.
module conway_mode_checker (
  input logic clk,
  input logic reset,
  input logic load_mode,
  input logic run_mode,
  input logic output_mode
);

  a_modes_exclusive: assert property (
    @(posedge clk) disable iff (reset) $onehot0({load_mode, run_mode, output_mode})
  );

endmodule

// File: tb/tb_conway_mode_controller.sv
// Scoreboarded bench for conway_mode_controller with a behavioural cell-state memory.
module tb_conway_mode_controller;

  localparam int DS = 5;
  localparam int GW = 8;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [GW-1:0] cmd_gens;
  logic          cmd_ready;
  logic          cmd_abort;
  logic          host_bit_valid;
  logic          host_bit;
  logic          load_mode;
  logic          run_mode;
  logic          output_mode;
  logic          serial_in;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DS-1:0] mem;
  logic          serial_out;
  logic          exp_q[$];

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int run_cnt = 0;
  int read_cnt = 0;
  int done_cnt = 0;

  conway_mode_controller #(.DATA_SIZE(DS), .GEN_WIDTH(GW)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_gens       (cmd_gens),
    .cmd_ready      (cmd_ready),
    .cmd_abort      (cmd_abort),
    .host_bit_valid (host_bit_valid),
    .host_bit       (host_bit),
    .load_mode      (load_mode),
    .run_mode       (run_mode),
    .output_mode    (output_mode),
    .serial_in      (serial_in),
    .out_valid      (out_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Cell memory: shift-in on load, MSB-first rotate with registered serial_out on read.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem        <= '0;
      serial_out <= 1'b0;
    end else if (load_mode) begin
      mem <= {mem[DS-2:0], serial_in};
    end else if (output_mode) begin
      serial_out <= mem[DS-1];
      mem        <= {mem[DS-2:0], mem[DS-1]};
    end
  end

  // Monitor: mode exclusivity, activity counts and scoreboard of read-out bits.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (int'(load_mode) + int'(run_mode) + int'(output_mode) > 1) begin
        errors++;
        $display("FAIL mode_excl: load=%0b run=%0b out=%0b, need at most one", load_mode, run_mode, output_mode);
      end
      if (load_mode) load_cnt++;
      if (run_mode) run_cnt++;
      if (output_mode) read_cnt++;
      if (done) done_cnt++;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: out_valid with serial_out=%0b, no bit expected", serial_out);
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (serial_out !== e) begin
            errors++;
            $display("FAIL sb_bit: serial_out=%0b expected %0b", serial_out, e);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns one ns into the first cycle after the accept edge.
  task automatic send_cmd(input logic [1:0] op, input logic [GW-1:0] n);
    tick();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_gens  = n;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({cmd_ready, busy, load_mode, run_mode, output_mode, out_valid, done} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_vals: got %b expected 1000000", {cmd_ready, busy, load_mode, run_mode, output_mode, out_valid, done});
    end
    host_bit = 1'b1;
    #1;
    checks++;
    if (serial_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_serial_in: got %0b expected 1", serial_in);
    end
    host_bit = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send_cmd(OP_RUN, 8'd10);
    tick();
    @(negedge clk);
    checks++;
    if (run_mode !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun: run_mode=%0b expected 1", run_mode);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({run_mode, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_async: {run,busy,ready}=%b expected 001", {run_mode, busy, cmd_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || mem !== 5'b00000) begin
      errors++;
      $display("FAIL reset_release: ready=%0b mem=%b expected 1 00000", cmd_ready, mem);
    end
  endtask

  task automatic test_load;
    logic [5:0] v;
    logic [5:0] b;
    int l0, d0, r0;
    v = 6'b110111;
    b = 6'b100011;
    l0 = load_cnt; d0 = done_cnt; r0 = read_cnt;
    send_cmd(OP_LOAD, 8'd0);
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_busy: busy=%0b ready=%0b expected 1 0", busy, cmd_ready);
    end
    for (int i = 5; i >= 0; i--) begin
      host_bit_valid = v[i];
      host_bit       = b[i];
      cmd_valid      = ~v[i];
      cmd_op         = OP_READ;
      tick();
    end
    host_bit_valid = 1'b0;
    cmd_valid      = 1'b0;
    cmd_op         = OP_NOP;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_done: done=%0b busy=%0b expected 1 0", done, busy);
    end
    tick();
    checks++;
    if (load_cnt - l0 != 5 || done_cnt - d0 != 1 || read_cnt != r0 || mem !== 5'b10011) begin
      errors++;
      $display("FAIL load_result: loads=%0d dones=%0d reads=%0d mem=%b expected 5 1 0 10011",
               load_cnt - l0, done_cnt - d0, read_cnt - r0, mem);
    end
  endtask

  task automatic test_run(input logic [GW-1:0] n);
    int r0;
    r0 = run_cnt;
    send_cmd(OP_RUN, n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      checks++;
      if (run_mode !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_cycle: N=%0d cycle %0d run=%0b done=%0b expected 1 0", n, i, run_mode, done);
      end
    end
    @(negedge clk);
    checks++;
    if (run_mode !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_end: N=%0d run=%0b done=%0b ready=%0b expected 0 1 1", n, run_mode, done, cmd_ready);
    end
    #1;
    checks++;
    if (run_cnt - r0 != int'(n)) begin
      errors++;
      $display("FAIL run_count: N=%0d got %0d run cycles", n, run_cnt - r0);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] b;
    b = 5'b01101;
    send_cmd(OP_RUN, 8'd2);
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%0b ready=%0b expected 1 1", done, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%0b ready=%0b expected 1 0", busy, cmd_ready);
    end
    for (int i = 4; i >= 0; i--) begin
      host_bit_valid = 1'b1;
      host_bit       = b[i];
      #1;
      checks++;
      if (load_mode !== 1'b1) begin
        errors++;
        $display("FAIL b2b_load_mode: bit %0d load_mode=%0b expected 1", i, load_mode);
      end
      tick();
    end
    host_bit_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem !== 5'b01101) begin
      errors++;
      $display("FAIL b2b_load_end: done=%0b mem=%b expected 1 01101", done, mem);
    end
  endtask

  task automatic test_read;
    logic [2:0] want;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    send_cmd(OP_READ, 8'd0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      want = {(i <= 5) ? 1'b1 : 1'b0, (i >= 2) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0};
      checks++;
      if ({output_mode, out_valid, done} !== want) begin
        errors++;
        $display("FAIL read_timing: cycle %0d {out_mode,valid,done}=%b expected %b", i, {output_mode, out_valid, done}, want);
      end
    end
    #1;
    checks++;
    if (exp_q.size() != 0 || mem !== 5'b01101) begin
      errors++;
      $display("FAIL read_restore: pending=%0d mem=%b expected 0 01101", exp_q.size(), mem);
    end
  endtask

  task automatic test_abort_read;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    send_cmd(OP_READ, 8'd0);
    tick();
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({output_mode, out_valid, done, busy} !== 4'b0100) begin
      errors++;
      $display("FAIL abort_next: {out_mode,valid,done,busy}=%b expected 0100", {output_mode, out_valid, done, busy});
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || done_cnt != d0 || mem !== 5'b10101 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_result: valid=%0b dones=%0d mem=%b pending=%0d expected 0 0 10101 0",
               out_valid, done_cnt - d0, mem, exp_q.size());
    end
  endtask

  task automatic test_dropped;
    int r0, rd0, l0;
    r0 = run_cnt; rd0 = read_cnt; l0 = load_cnt;
    send_cmd(OP_RUN, 8'd4);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = (i % 2 == 1) ? OP_LOAD : OP_READ;
      @(negedge clk);
      checks++;
      if (run_mode !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL drop_busy: cycle %0d run=%0b ready=%0b expected 1 0", i, run_mode, cmd_ready);
      end
      tick();
    end
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: done=%0b busy=%0b expected 1 0", done, busy);
    end
    tick();
    checks++;
    if (run_cnt - r0 != 4 || read_cnt != rd0 || load_cnt != l0 || mem !== 5'b10101) begin
      errors++;
      $display("FAIL drop_result: runs=%0d reads=%0d loads=%0d mem=%b expected 4 0 0 10101",
               run_cnt - r0, read_cnt - rd0, load_cnt - l0, mem);
    end
  endtask

  initial begin
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_op         = OP_NOP;
    cmd_gens       = '0;
    cmd_abort      = 1'b0;
    host_bit_valid = 1'b0;
    host_bit       = 1'b0;
    test_reset();
    test_load();
    test_run(8'd3);
    test_run(8'd0);
    test_run(8'd255);
    test_back_to_back();
    test_read();
    test_abort_read();
    test_dropped();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conway_mode_controller.md
# conway_mode_controller

Sequencer for the cell-state system memory: accepts host commands (LOAD, RUN, READ) and drives the memory's mutually exclusive `load_mode`, `run_mode` and `output_mode` controls for exact cycle counts. It counts serial bits during LOAD and generations during RUN. During READ it performs exactly one full rotation, so the memory contents are restored, and it qualifies the memory's `serial_out` with a valid strobe. It sits between the host command interface and the system memory / next-state datapath.

## Interface
- `DATA_SIZE`, 5, number of cells in the system memory; sets the LOAD and READ lengths.
- `GEN_WIDTH`, 8, width of the generation-count field.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host command strobe.
- `cmd_op`  in  2  00 NOP, 01 LOAD, 10 RUN, 11 READ.
- `cmd_gens`  in  GEN_WIDTH  generation count; sampled with a RUN command only.
- `cmd_ready`  out  1  controller can accept a command (state IDLE).
- `cmd_abort`  in  1  terminate the current command.
- `host_bit_valid`  in  1  LOAD data strobe.
- `host_bit`  in  1  LOAD data bit.
- `load_mode`  out  1  to memory.
- `run_mode`  out  1  to memory.
- `output_mode`  out  1  to memory.
- `serial_in`  out  1  to memory; carries `host_bit`.
- `out_valid`  out  1  memory `serial_out` holds a valid output bit this cycle.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **States:** IDLE, LOAD, RUN, READ. Encode one-hot or binary; the choice is not visible at ports.
- **Reset values:** state IDLE, all counters 0.
  - `load_mode`, `run_mode`, `output_mode`, `out_valid`, `done`, `busy` = 0.
  - `cmd_ready` = 1.
  - `serial_in` = `host_bit`.
- **Command acceptance:** a command is accepted when `cmd_valid` & `cmd_ready` are high at a rising edge.
  - NOP: accepted with no effect and no `done` pulse.
- **IDLE → LOAD** on LOAD. Bit counter cleared.
  - `load_mode` = LOAD & `host_bit_valid` (combinational), so each valid bit shifts exactly once.
  - `serial_in` = `host_bit` at all times.
  - Each edge with `load_mode` high increments the bit counter.
  - When the DATA_SIZE-th bit is accepted → IDLE and `done`.
- **IDLE → RUN** on RUN with `cmd_gens` = N ≥ 1. The generation counter loads N.
  - `run_mode` = (state == RUN).
  - The counter decrements each RUN cycle; on the cycle the counter equals 1 → IDLE and `done`.
  - Result: exactly N `run_mode` cycles.
- **RUN with N = 0:** state remains IDLE, no `run_mode` cycle, `done` pulses the next cycle.
- **IDLE → READ** on READ.
  - `output_mode` = (state == READ) for exactly DATA_SIZE cycles, then IDLE and `done`.
  - `out_valid` is `output_mode` registered: high for the DATA_SIZE cycles following each `output_mode` cycle.
  - Bits appear MSB first; the memory ends rotated back to its original contents.
- **Mutual exclusion:** at most one of the three mode outputs is high in any cycle. This is a required assertion.
- **`cmd_abort`:** abort in a non-IDLE state → IDLE at the next edge, counters cleared, no `done` pulse.
  - A pending `out_valid` (already-issued shift) still pulses once.
  - Abort in IDLE is ignored; abort has priority over command acceptance in the same cycle.
- **Ignored inputs:**
  - `host_bit_valid` outside LOAD.
  - `cmd_valid` while busy; the command is dropped, not queued.
- **`done` and back-to-back commands:** `done` is registered and is high during the first IDLE cycle after completion. A new command may be accepted in that same cycle.
- **Reset mid-operation:** immediate return to reset values. A partially loaded memory is not restored by this block.

## Timing
- Accept edge at cycle k: the mode output first goes high in cycle k+1.
- LOAD latency equals the number of cycles until DATA_SIZE valid bits have arrived; gaps in `host_bit_valid` stall without limit.
- RUN occupies cycles k+1 … k+N; `done` is in cycle k+N+1.
- READ: `output_mode` in k+1 … k+DATA_SIZE; `out_valid` in k+2 … k+DATA_SIZE+1; `done` in k+DATA_SIZE+1.
- The generation counter is GEN_WIDTH bits; N = 2^GEN_WIDTH−1 is legal, with no wrap.
- The bit counter is ⌈log2(DATA_SIZE+1)⌉ bits.

## Test plan
- **Reset:** assert `reset` mid-RUN → all mode outputs 0 asynchronously, `cmd_ready` = 1 after release; the memory reads 00000 if it is reset alongside.
- **LOAD 1,0,0,1,1 with one idle gap** (`host_bit_valid` low one cycle) → exactly 5 `load_mode` cycles, memory = 10011, `done` once.
- **RUN N = 3** → `run_mode` high exactly 3 consecutive cycles, `done` the next cycle. **RUN N = 0** → no `run_mode`, `done` after 1 cycle.
- **READ after memory = 01101** → `out_valid` samples of `serial_out` = 0,1,1,0,1; memory back to 01101; `done` aligned with the final `out_valid`.
- **Abort during READ after 2 shifts** → `output_mode` low next cycle, no `done`, memory = 10101.
- **Commands issued while busy are dropped**, with the one-hot mode check held throughout; a LOAD accepted in the `done` cycle of a RUN starts immediately.
